// File: rtl/csr_file_pkg.sv
// Shared types and constants for the machine-mode CSR file: CSR select codes,
// operation encoding, cause codes and the trap request bundle.
package csr_file_pkg;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MSI      = 3;
  localparam int MIP_MTI      = 7;
  localparam int MIP_MEI      = 11;

  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  typedef enum logic [3:0] {
    CSR_MSTATUS   = 4'd0,
    CSR_MISA      = 4'd1,
    CSR_MIE       = 4'd2,
    CSR_MTVEC     = 4'd3,
    CSR_MSCRATCH  = 4'd4,
    CSR_MEPC      = 4'd5,
    CSR_MCAUSE    = 4'd6,
    CSR_MTVAL     = 4'd7,
    CSR_MIP       = 4'd8,
    CSR_MCYCLE    = 4'd9,
    CSR_MINSTRET  = 4'd10,
    CSR_MVENDORID = 4'd11,
    CSR_MARCHID   = 4'd12,
    CSR_MIMPID    = 4'd13,
    CSR_MHARTID   = 4'd14
  } destinationCSR_;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } CSROp_;

  // Bit 5 carries the interrupt flag so interrupt and exception codes that
  // share a numeric value remain distinct enum members.
  typedef enum logic [5:0] {
    EXC_ILLEGAL  = 6'b0_00010,
    EXC_BREAK    = 6'b0_00011,
    EXC_ECALL_M  = 6'b0_01011,
    INT_M_SOFT   = 6'b1_00011,
    INT_M_TIMER  = 6'b1_00111,
    INT_M_EXT    = 6'b1_01011
  } causeCode_;

  typedef struct packed {
    logic        interrupt;
    logic [4:0]  code;
    logic [31:0] pc;
    logic [31:0] value;
  } trapRequest_;

  function automatic logic [31:0] csr_apply(input CSROp_ op, input logic [31:0] old,
                                            input logic [31:0] operand);
    case (op)
      CSR_OP_RW: csr_apply = operand;
      CSR_OP_RS: csr_apply = old | operand;
      CSR_OP_RC: csr_apply = old & ~operand;
      default:   csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_file_counter.sv
// Free-running counter of parametrised width with 32-bit split access;
// a write to either half replaces that cycle's increment.
module csr_counter
  import csr_file_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_lo,
  output logic [31:0] rd_hi
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_written;

  if (WIDTH > 32) begin : g_wide
    assign hi_written = {wr_data[WIDTH-33:0], cnt_q[31:0]};
    assign rd_hi      = 32'(cnt_q[WIDTH-1:32]);
  end else begin : g_narrow
    assign hi_written = cnt_q;
    assign rd_hi      = '0;
  end

  assign rd_lo = cnt_q[31:0];

  always_comb begin
    cnt_d = cnt_q + WIDTH'(inc);
    if (wr_lo) begin
      cnt_d        = cnt_q;
      cnt_d[31:0]  = wr_data;
    end else if (wr_hi) begin
      cnt_d        = hi_written;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational reads, masked CSR writes, trap entry,
// MRET sequencing, registered interrupt request and PC redirect.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned  COUNTER_WIDTH = 64,
  parameter bit           VECTORED_EN   = 1'b1,
  parameter logic [31:0]  HART_ID       = 32'd0,
  parameter logic [31:0]  MISA_VALUE    = 32'h4000_0100,
  parameter logic [31:0]  TRAP_BASE     = TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  readCSR,
  input  logic        readHigh,
  output logic [31:0] readData,
  input  logic        writeEnable,
  input  logic [3:0]  writeCSR,
  input  logic [1:0]  CSROp,
  input  logic        writeHigh,
  input  logic [31:0] writeOperand,
  input  logic        retire,
  input  logic        trapValid,
  input  logic        trapInterrupt,
  input  logic [4:0]  trapCode,
  input  logic [31:0] trapPC,
  input  logic [31:0] trapValue,
  input  logic        mretValid,
  input  logic        irqSoftware,
  input  logic        irqTimer,
  input  logic        irqExternal,
  output logic        interruptReq,
  output logic        redirectValid,
  output logic [31:0] redirectPC
);

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // MODE bit 1 is never stored, so MODE=2 reads back 0 and MODE=3 reads back 1.
  function automatic logic [31:0] mtvec_mask(input logic [31:0] v);
    mtvec_mask = {v[31:2], 1'b0, v[0] & VECTORED_EN};
  endfunction

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mip_q, mip_d;
  logic        interrupt_req_q, interrupt_req_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic        mcycle_wr_lo, mcycle_wr_hi, minstret_wr_lo, minstret_wr_hi;
  logic [31:0] csr_val [16];
  logic [31:0] mstatus_rd, wr_old, wr_new, trap_target;
  logic        do_write;
  trapRequest_ trap_req;

  assign trap_req = '{interrupt: trapInterrupt, code: trapCode, pc: trapPC, value: trapValue};

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  always_comb begin
    for (int i = 0; i < 16; i++) csr_val[i] = '0;
    csr_val[CSR_MSTATUS]  = mstatus_rd;
    csr_val[CSR_MISA]     = MISA_VALUE;
    csr_val[CSR_MIE]      = mie_q;
    csr_val[CSR_MTVEC]    = mtvec_q;
    csr_val[CSR_MSCRATCH] = mscratch_q;
    csr_val[CSR_MEPC]     = mepc_q;
    csr_val[CSR_MCAUSE]   = mcause_q;
    csr_val[CSR_MTVAL]    = mtval_q;
    csr_val[CSR_MIP]      = mip_q;
    csr_val[CSR_MCYCLE]   = mcycle_lo;
    csr_val[CSR_MINSTRET] = minstret_lo;
    csr_val[CSR_MHARTID]  = HART_ID;
  end

  always_comb begin
    if (!readHigh)                   readData = csr_val[readCSR];
    else if (readCSR == CSR_MCYCLE)   readData = mcycle_hi;
    else if (readCSR == CSR_MINSTRET) readData = minstret_hi;
    else                             readData = '0;

    if (!writeHigh)                   wr_old = csr_val[writeCSR];
    else if (writeCSR == CSR_MCYCLE)   wr_old = mcycle_hi;
    else if (writeCSR == CSR_MINSTRET) wr_old = minstret_hi;
    else                              wr_old = '0;
  end

  assign wr_new   = csr_apply(CSROp_'(CSROp), wr_old, writeOperand);
  assign do_write = writeEnable && !trapValid && !mretValid && (CSROp_'(CSROp) != CSR_OP_NONE);

  always_comb begin
    trap_target = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && trap_req.interrupt)
      trap_target = trap_target + {25'b0, trap_req.code, 2'b00};
  end

  always_comb begin
    mstatus_mie_d    = mstatus_mie_q;
    mstatus_mpie_d   = mstatus_mpie_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    mtval_d          = mtval_q;
    mie_d            = mie_q;
    mscratch_d       = mscratch_q;
    mtvec_d          = mtvec_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    mcycle_wr_lo     = 1'b0;
    mcycle_wr_hi     = 1'b0;
    minstret_wr_lo   = 1'b0;
    minstret_wr_hi   = 1'b0;

    mip_d          = '0;
    mip_d[MIP_MSI] = irqSoftware;
    mip_d[MIP_MTI] = irqTimer;
    mip_d[MIP_MEI] = irqExternal;

    if (trapValid) begin
      mepc_d           = {trap_req.pc[31:2], 2'b00};
      mcause_d         = {trap_req.interrupt, 26'b0, trap_req.code};
      mtval_d          = trap_req.value;
      mstatus_mpie_d   = mstatus_mie_q;
      mstatus_mie_d    = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_target;
    end else if (mretValid) begin
      mstatus_mie_d    = mstatus_mpie_q;
      mstatus_mpie_d   = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
    end else if (do_write) begin
      case (writeCSR)
        CSR_MSTATUS: begin
          mstatus_mie_d  = wr_new[MSTATUS_MIE];
          mstatus_mpie_d = wr_new[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wr_new & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = mtvec_mask(wr_new);
        CSR_MSCRATCH: mscratch_d = wr_new;
        CSR_MEPC:     mepc_d     = {wr_new[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wr_new;
        CSR_MTVAL:    mtval_d    = wr_new;
        CSR_MCYCLE: begin
          mcycle_wr_lo = !writeHigh;
          mcycle_wr_hi = writeHigh;
        end
        CSR_MINSTRET: begin
          minstret_wr_lo = !writeHigh;
          minstret_wr_hi = writeHigh;
        end
        default: ;
      endcase
    end

    // Uses the already-registered mip, giving two cycles from pin to request.
    interrupt_req_d = mstatus_mie_d & |(mie_d & mip_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q    <= 1'b0;
      mstatus_mpie_q   <= 1'b0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mie_q            <= '0;
      mscratch_q       <= '0;
      mtvec_q          <= TRAP_BASE;
      mip_q            <= '0;
      interrupt_req_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mstatus_mie_q    <= mstatus_mie_d;
      mstatus_mpie_q   <= mstatus_mpie_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      mtval_q          <= mtval_d;
      mie_q            <= mie_d;
      mscratch_q       <= mscratch_d;
      mtvec_q          <= mtvec_d;
      mip_q            <= mip_d;
      interrupt_req_q  <= interrupt_req_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_mcycle (
    .clk     (clk),
    .reset   (reset),
    .inc     (1'b1),
    .wr_lo   (mcycle_wr_lo),
    .wr_hi   (mcycle_wr_hi),
    .wr_data (wr_new),
    .rd_lo   (mcycle_lo),
    .rd_hi   (mcycle_hi)
  );

  csr_counter #(.WIDTH(COUNTER_WIDTH)) u_minstret (
    .clk     (clk),
    .reset   (reset),
    .inc     (retire),
    .wr_lo   (minstret_wr_lo),
    .wr_hi   (minstret_wr_hi),
    .wr_data (wr_new),
    .rd_lo   (minstret_lo),
    .rd_hi   (minstret_hi)
  );

  assign interruptReq  = interrupt_req_q;
  assign redirectValid = redirect_valid_q;
  assign redirectPC    = redirect_pc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed scoreboard bench for csr_file: expectations are queued as stimulus
// is applied and popped when the matching output is sampled.
`timescale 1ns/1ps
module tb_csr_file;
  import csr_file_pkg::*;

  localparam logic [31:0] TB_TRAP_BASE = 32'h0000_0200;
  localparam logic [31:0] TB_HART      = 32'h0000_0005;
  localparam logic [31:0] TB_MISA      = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  readCSR;
  logic        readHigh;
  logic [31:0] readData, readData_nv;
  logic        writeEnable;
  logic [3:0]  writeCSR;
  logic [1:0]  CSROp;
  logic        writeHigh;
  logic [31:0] writeOperand;
  logic        retire;
  logic        trapValid, trapInterrupt;
  logic [4:0]  trapCode;
  logic [31:0] trapPC, trapValue;
  logic        mretValid;
  logic        irqSoftware, irqTimer, irqExternal;
  logic        interruptReq, redirectValid;
  logic [31:0] redirectPC;
  logic        interruptReq_nv, redirectValid_nv;
  logic [31:0] redirectPC_nv;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  always #50 clk = ~clk;

  csr_file #(.COUNTER_WIDTH(64), .VECTORED_EN(1'b1), .HART_ID(TB_HART),
             .MISA_VALUE(TB_MISA), .TRAP_BASE(TB_TRAP_BASE)) dut (
    .clk(clk), .reset(reset), .readCSR(readCSR), .readHigh(readHigh), .readData(readData),
    .writeEnable(writeEnable), .writeCSR(writeCSR), .CSROp(CSROp), .writeHigh(writeHigh),
    .writeOperand(writeOperand), .retire(retire), .trapValid(trapValid),
    .trapInterrupt(trapInterrupt), .trapCode(trapCode), .trapPC(trapPC), .trapValue(trapValue),
    .mretValid(mretValid), .irqSoftware(irqSoftware), .irqTimer(irqTimer),
    .irqExternal(irqExternal), .interruptReq(interruptReq), .redirectValid(redirectValid),
    .redirectPC(redirectPC)
  );

  csr_file #(.COUNTER_WIDTH(64), .VECTORED_EN(1'b0), .HART_ID(TB_HART),
             .MISA_VALUE(TB_MISA), .TRAP_BASE(TB_TRAP_BASE)) dut_nv (
    .clk(clk), .reset(reset), .readCSR(readCSR), .readHigh(readHigh), .readData(readData_nv),
    .writeEnable(writeEnable), .writeCSR(writeCSR), .CSROp(CSROp), .writeHigh(writeHigh),
    .writeOperand(writeOperand), .retire(retire), .trapValid(trapValid),
    .trapInterrupt(trapInterrupt), .trapCode(trapCode), .trapPC(trapPC), .trapValue(trapValue),
    .mretValid(mretValid), .irqSoftware(irqSoftware), .irqTimer(irqTimer),
    .irqExternal(irqExternal), .interruptReq(interruptReq_nv), .redirectValid(redirectValid_nv),
    .redirectPC(redirectPC_nv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_asserts++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic hi, input logic [31:0] v);
    expect_val(tag, v);
    readCSR  = a;
    readHigh = hi;
    #1;
    check(readData);
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [1:0] op, input logic [31:0] v,
                           input logic hi);
    writeEnable  = 1'b1;
    writeCSR     = a;
    CSROp        = op;
    writeOperand = v;
    writeHigh    = hi;
    tick();
    writeEnable  = 1'b0;
    CSROp        = 2'd0;
    writeHigh    = 1'b0;
  endtask

  task automatic set_trap(input causeCode_ cause, input logic [31:0] pc, input logic [31:0] val);
    logic [5:0] c;
    c             = cause;
    trapValid     = 1'b1;
    trapInterrupt = c[5];
    trapCode      = c[4:0];
    trapPC        = pc;
    trapValue     = val;
  endtask

  initial begin
    reset = 1'b1; readCSR = '0; readHigh = 1'b0; writeEnable = 1'b0; writeCSR = '0;
    CSROp = '0; writeHigh = 1'b0; writeOperand = '0; retire = 1'b0; trapValid = 1'b0;
    trapInterrupt = 1'b0; trapCode = '0; trapPC = '0; trapValue = '0; mretValid = 1'b0;
    irqSoftware = 1'b0; irqTimer = 1'b0; irqExternal = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state of every CSR and output
    rd("rst_mstatus",   CSR_MSTATUS,   1'b0, 32'h0000_1800);
    rd("rst_misa",      CSR_MISA,      1'b0, TB_MISA);
    rd("rst_mie",       CSR_MIE,       1'b0, 32'h0);
    rd("rst_mtvec",     CSR_MTVEC,     1'b0, TB_TRAP_BASE);
    rd("rst_mscratch",  CSR_MSCRATCH,  1'b0, 32'h0);
    rd("rst_mepc",      CSR_MEPC,      1'b0, 32'h0);
    rd("rst_mcause",    CSR_MCAUSE,    1'b0, 32'h0);
    rd("rst_mtval",     CSR_MTVAL,     1'b0, 32'h0);
    rd("rst_mip",       CSR_MIP,       1'b0, 32'h0);
    rd("rst_mcycle",    CSR_MCYCLE,    1'b0, 32'h0);
    rd("rst_mcycleh",   CSR_MCYCLE,    1'b1, 32'h0);
    rd("rst_minstret",  CSR_MINSTRET,  1'b0, 32'h0);
    rd("rst_mvendorid", CSR_MVENDORID, 1'b0, 32'h0);
    rd("rst_marchid",   CSR_MARCHID,   1'b0, 32'h0);
    rd("rst_mimpid",    CSR_MIMPID,    1'b0, 32'h0);
    rd("rst_mhartid",   CSR_MHARTID,   1'b0, TB_HART);
    rd("hi_noncounter", CSR_MSTATUS,   1'b1, 32'h0);
    expect_val("rst_interruptReq", 32'h0);  check(32'(interruptReq));
    expect_val("rst_redirectValid", 32'h0); check(32'(redirectValid));
    expect_val("rst_redirectPC", 32'h0);    check(redirectPC);

    // mtvec MODE legalisation, vectored and non-vectored builds
    csr_write(CSR_MTVEC, CSR_OP_RW, 32'h8000_0103, 1'b0);
    rd("mtvec_vec", CSR_MTVEC, 1'b0, 32'h8000_0101);
    expect_val("mtvec_novec", 32'h8000_0100);
    check(readData_nv);

    // Interrupt request path and vectored interrupt trap
    csr_write(CSR_MTVEC, CSR_OP_RW, 32'h0000_0101, 1'b0);
    csr_write(CSR_MSTATUS, CSR_OP_RW, 32'h0000_0008, 1'b0);
    csr_write(CSR_MIE, CSR_OP_RW, 32'h0000_0080, 1'b0);
    rd("mstatus_mie1", CSR_MSTATUS, 1'b0, 32'h0000_1808);
    irqTimer = 1'b1;
    tick();
    expect_val("irq_lat1", 32'h0); check(32'(interruptReq));
    rd("mip_timer", CSR_MIP, 1'b0, 32'h0000_0080);
    tick();
    expect_val("irq_lat2", 32'h1); check(32'(interruptReq));
    set_trap(INT_M_TIMER, 32'h0000_1234, 32'h0);
    expect_val("int_redirect_valid", 32'h1);
    expect_val("int_redirect_pc", 32'h0000_011C);
    expect_val("int_irq_drop", 32'h0);
    tick();
    trapValid = 1'b0;
    check(32'(redirectValid));
    check(redirectPC);
    check(32'(interruptReq));
    rd("int_mcause",  CSR_MCAUSE,  1'b0, 32'h8000_0007);
    rd("int_mstatus", CSR_MSTATUS, 1'b0, 32'h0000_1880);
    rd("int_mepc",    CSR_MEPC,    1'b0, 32'h0000_1234);
    irqTimer = 1'b0;
    tick();
    expect_val("redirect_single_pulse", 32'h0); check(32'(redirectValid));

    // Exception immediately followed by MRET
    csr_write(CSR_MSTATUS, CSR_OP_RW, 32'h0000_0008, 1'b0);
    set_trap(EXC_ILLEGAL, 32'h8000_0042, 32'h0000_DEAD);
    expect_val("exc_redirect_valid", 32'h1);
    expect_val("exc_redirect_pc", 32'h0000_0100);
    tick();
    trapValid = 1'b0;
    mretValid = 1'b1;
    check(32'(redirectValid));
    check(redirectPC);
    rd("exc_mepc",    CSR_MEPC,    1'b0, 32'h8000_0040);
    rd("exc_mtval",   CSR_MTVAL,   1'b0, 32'h0000_DEAD);
    rd("exc_mcause",  CSR_MCAUSE,  1'b0, 32'h0000_0002);
    expect_val("mret_redirect_valid", 32'h1);
    expect_val("mret_redirect_pc", 32'h8000_0040);
    tick();
    mretValid = 1'b0;
    check(32'(redirectValid));
    check(redirectPC);
    rd("mret_mstatus", CSR_MSTATUS, 1'b0, 32'h0000_1888);
    tick();
    expect_val("mret_single_pulse", 32'h0); check(32'(redirectValid));

    // Counter carry across halves and write-over-increment
    csr_write(CSR_MCYCLE, CSR_OP_RW, 32'hFFFF_FFFF, 1'b0);
    rd("mcycle_written", CSR_MCYCLE, 1'b0, 32'hFFFF_FFFF);
    rd("mcycleh_held",   CSR_MCYCLE, 1'b1, 32'h0);
    tick();
    rd("mcycle_wrap_lo", CSR_MCYCLE, 1'b0, 32'h0);
    rd("mcycle_wrap_hi", CSR_MCYCLE, 1'b1, 32'h1);
    retire = 1'b1;
    csr_write(CSR_MINSTRET, CSR_OP_RW, 32'h0000_0005, 1'b0);
    rd("minstret_write_wins", CSR_MINSTRET, 1'b0, 32'h5);
    tick();
    retire = 1'b0;
    rd("minstret_retire", CSR_MINSTRET, 1'b0, 32'h6);

    // Set/clear ops and write masks
    csr_write(CSR_MSCRATCH, CSR_OP_RW, 32'h0000_A5A5, 1'b0);
    csr_write(CSR_MSCRATCH, CSR_OP_RS, 32'h0000_00F0, 1'b0);
    csr_write(CSR_MSCRATCH, CSR_OP_RC, 32'h0000_0005, 1'b0);
    rd("mscratch_rs_rc", CSR_MSCRATCH, 1'b0, 32'h0000_A5F0);
    csr_write(CSR_MIE, CSR_OP_RW, 32'hFFFF_FFFF, 1'b0);
    rd("mie_mask", CSR_MIE, 1'b0, 32'h0000_0888);
    csr_write(CSR_MEPC, CSR_OP_RW, 32'h0000_0013, 1'b0);
    rd("mepc_mask", CSR_MEPC, 1'b0, 32'h0000_0010);
    csr_write(CSR_MISA, CSR_OP_RW, 32'h0, 1'b0);
    rd("misa_ro", CSR_MISA, 1'b0, TB_MISA);
    csr_write(CSR_MIP, CSR_OP_RW, 32'hFFFF_FFFF, 1'b0);
    rd("mip_ro", CSR_MIP, 1'b0, 32'h0);

    // Trap beats MRET beats write in the same cycle
    set_trap(EXC_ECALL_M, 32'h0000_0203, 32'h0000_0077);
    mretValid    = 1'b1;
    writeEnable  = 1'b1;
    writeCSR     = CSR_MSCRATCH;
    CSROp        = CSR_OP_RW;
    writeOperand = 32'h0000_1234;
    expect_val("prio_redirect_pc", 32'h0000_0100);
    tick();
    trapValid = 1'b0; mretValid = 1'b0; writeEnable = 1'b0; CSROp = 2'd0;
    check(redirectPC);
    rd("prio_mscratch", CSR_MSCRATCH, 1'b0, 32'h0000_A5F0);
    rd("prio_mcause",   CSR_MCAUSE,   1'b0, 32'h0000_000B);
    rd("prio_mepc",     CSR_MEPC,     1'b0, 32'h0000_0200);
    rd("prio_mstatus",  CSR_MSTATUS,  1'b0, 32'h0000_1880);

    // Reset while a trap is being taken cancels the redirect
    set_trap(INT_M_EXT, 32'h0000_0400, 32'h0);
    reset = 1'b1;
    tick();
    trapValid = 1'b0;
    expect_val("rst_cancel_redirect", 32'h0); check(32'(redirectValid));
    reset = 1'b0;
    rd("rst2_mtvec",    CSR_MTVEC,    1'b0, TB_TRAP_BASE);
    rd("rst2_mscratch", CSR_MSCRATCH, 1'b0, 32'h0);
    rd("rst2_minstret", CSR_MINSTRET, 1'b0, 32'h0);
    rd("rst2_mstatus",  CSR_MSTATUS,  1'b0, 32'h0000_1800);

    if (sb.size() != 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
